// File: rtl/csel_adder_pipe_if.sv
// Stream bus for csel_adder_pipe: an operand beat in, a result beat out,
// each side with its own valid/ready handshake.
interface csel_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             prop;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, prop
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, prop
    );
endinterface

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: BPS blocks of BLK bits resolved
// per stage, carries registered between stages, elastic valid/ready pipe.
module csel_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           cmsb,
    output logic           p
);
    logic [BLK:0] r0, r1;

    // both carry hypotheses in parallel, then a late select on the real carry
    assign r0       = {1'b0, a} + {1'b0, b};
    assign r1       = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);
    assign {co, s}  = ci ? r1 : r0;
    assign cmsb     = a[BLK-1] ^ b[BLK-1] ^ s[BLK-1];
    assign p        = &(a ^ b);
endmodule

module csel_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4,
    parameter int BPS   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    csel_adder_pipe_if.slave   bus
);
    localparam int SW     = BLK * BPS;
    localparam int STAGES = WIDTH / SW;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;   // already conditionally inverted for sub
        logic [WIDTH-1:0] s;
        logic             c;
        logic             p;
    } stg_t;

    stg_t             src [STAGES];
    stg_t             nxt [STAGES];
    stg_t             q   [STAGES];
    logic [STAGES-1:0] vq;
    logic [STAGES:0]  vld_pipe;
    logic [STAGES:0]  rdy;
    logic             cmsb_last;
    logic             ovf_q;

    assign vld_pipe    = {vq, bus.in_valid};
    assign rdy[STAGES] = bus.out_ready;
    assign src[0]      = '{a: bus.a, b: bus.b ^ {WIDTH{bus.sub}}, s: '0,
                           c: bus.cin ^ bus.sub, p: 1'b1};

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [BPS:0]     bc;
        logic [BPS-1:0]   bm, bp;
        logic [SW-1:0]    ss;
        logic [WIDTH-1:0] s_new;

        if (k > 0) begin : g_src
            assign src[k] = q[k-1];
        end

        assign rdy[k] = ~vld_pipe[k+1] | rdy[k+1];
        assign bc[0]  = src[k].c;

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            csel_block #(.BLK(BLK)) u_blk (
                .a    (src[k].a[k*SW + j*BLK +: BLK]),
                .b    (src[k].b[k*SW + j*BLK +: BLK]),
                .ci   (bc[j]),
                .s    (ss[j*BLK +: BLK]),
                .co   (bc[j+1]),
                .cmsb (bm[j]),
                .p    (bp[j])
            );
        end

        always_comb begin
            s_new = src[k].s;
            s_new[k*SW +: SW] = ss;
        end

        assign nxt[k] = '{a: src[k].a, b: src[k].b, s: s_new,
                          c: bc[BPS], p: src[k].p & (&bp)};

        if (k == STAGES-1) begin : g_last
            assign cmsb_last = bm[BPS-1];
        end
    end

    // a stage takes its upstream neighbour whenever it is empty or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq    <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vq[k] <= vld_pipe[k];
                    if (vld_pipe[k]) q[k] <= nxt[k];
                end
            end
            if (rdy[STAGES-1] && vld_pipe[STAGES-1])
                ovf_q <= cmsb_last ^ nxt[STAGES-1].c;
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vq[STAGES-1];
    assign bus.sum       = q[STAGES-1].s;
    assign bus.cout      = q[STAGES-1].c;
    assign bus.prop      = q[STAGES-1].p;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe: table vectors, stall/bubble/reset
// sequences and a random burst, all checked at the falling edge.
module tb_csel_adder_pipe;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         prop;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        res_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csel_adder_pipe_if #(.WIDTH(W)) bus ();

    csel_adder_pipe #(.WIDTH(W), .BLK(4), .BPS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t sb[$];
    res_t exp_cur;
    res_t hold_r;
    logic hold_v = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   out_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t r;
        logic [W-1:0] bb;
        logic [W:0]   t;
        bb     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ^ cin);
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
        r.prop = &(a ^ bb);
        return r;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.exp = model(a, b, cin, sub);
        return v;
    endfunction

    // handshakes complete on the next rising edge, so sample them here
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", bus.in_ready, (sb.size() < 4) || bus.out_ready);
            if (hold_v) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_sum",   bus.sum,  hold_r.sum);
                chk("hold_cout",  bus.cout, hold_r.cout);
                chk("hold_ovf",   bus.ovf,  hold_r.ovf);
                chk("hold_prop",  bus.prop, hold_r.prop);
            end
            hold_v      = bus.out_valid && !bus.out_ready;
            hold_r.sum  = bus.sum;
            hold_r.cout = bus.cout;
            hold_r.ovf  = bus.ovf;
            hold_r.prop = bus.prop;
            if (bus.out_valid && bus.out_ready) begin
                res_t e;
                out_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out: got sum %0h expected no beat", bus.sum);
                end else begin
                    e = sb.pop_front();
                    chk("sum",  bus.sum,  e.sum);
                    chk("cout", bus.cout, e.cout);
                    chk("ovf",  bus.ovf,  e.ovf);
                    chk("prop", bus.prop, e.prop);
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(exp_cur);
        end
    end

    task automatic send(input vec_t v);
        int n;
        n = 0;
        bus.a = v.a; bus.b = v.b; bus.cin = v.cin; bus.sub = v.sub;
        exp_cur = v.exp;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        vec_t v;
        int   c0;

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;

        tbl[0]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b0, '{32'h00000008, 1'b0, 1'b0, 1'b0}};
        tbl[1]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        tbl[2]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
        tbl[3]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
        tbl[4]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
        tbl[5]  = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b1}};
        tbl[6]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, '{32'h00000006, 1'b1, 1'b0, 1'b0}};
        tbl[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        tbl[8]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0}};
        tbl[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}};
        tbl[10] = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b1, '{32'h0000FFFE, 1'b1, 1'b0, 1'b0}};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sum",  bus.sum,  '0);
        chk("rst_cout", bus.cout, 1'b0);
        chk("rst_ovf",  bus.ovf,  1'b0);
        chk("rst_prop", bus.prop, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // latency: accepted on edge n, visible after edge n+3
        bus.a = tbl[0].a; bus.b = tbl[0].b; bus.cin = tbl[0].cin; bus.sub = tbl[0].sub;
        exp_cur = tbl[0].exp;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("lat_accept", bus.in_ready, 1'b1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("lat_valid_e%0d", i), bus.out_valid, i == 3);
        end
        @(posedge clk);
        #1;

        // table vectors, back to back
        for (int i = 0; i < 11; i++) send(tbl[i]);
        drain();

        // 8 beats with a 3-cycle output stall mid-stream
        c0 = out_cnt;
        fork
            for (int i = 0; i < 8; i++) send(mk(32'(i), 32'(i) << 28, 1'b0, 1'b0));
            begin
                idle(3);
                bus.out_ready = 1'b0;
                idle(3);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("b2b_count", out_cnt - c0, 8);

        // isolated beats into a stalled pipe collapse into 4 slots
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(mk(32'h1000 * (i + 1), 32'h00000777, 1'(i), 1'(i >> 1)));
            idle(2);
        end
        @(negedge clk);
        chk("bubble_full_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();

        // reset with 3 beats in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(mk(32'h12345678 + 32'(i), 32'h11111111, 1'b0, 1'b0));
        idle(2);
        @(negedge clk);
        chk("flush_pre_valid", bus.out_valid, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        hold_v = 1'b0;
        #1;
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_sum",  bus.sum,  '0);
        chk("flush_cout", bus.cout, 1'b0);
        chk("flush_ovf",  bus.ovf,  1'b0);
        chk("flush_prop", bus.prop, 1'b0);
        bus.out_ready = 1'b1;
        idle(2);
        rst_n = 1'b1;
        c0 = out_cnt;
        idle(10);
        chk("flush_no_out", out_cnt - c0, 0);

        // random burst against random back-pressure
        c0 = out_cnt;
        fork
            for (int i = 0; i < 40; i++) begin
                v = mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                send(v);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        drain();
        chk("rand_count", out_cnt - c0, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
